dds_par_ctrl: RTL and testbench
===============================

// Module: dds_par_ctrl
// PURPOSE
//  Sequencer for the DDS byte-wide parallel port (CSn/RWn/PCLK/IOup/8-bit bidir data).
//  Turns one-register read/write commands from the PS-side register block into exact
//  pin-level bus cycles and returns read data. Optionally pulses IO_update after a write.
//  Sits between the AXI-lite DDS register bank and the top-level jc/jd pin assignments.
// PARAMETERS
//  CLK_DIV  2  clk cycles per bus phase (PCLK half-period); legal range >=1
//  IOUP_W   4  IO_update pulse width in clk cycles; legal range >=1
// PORTS
//  clk          in   1  system clock; all logic on rising edge
//  rstn         in   1  asynchronous active-low reset
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  high in IDLE only; command accepted when cmd_valid&cmd_ready
//  cmd_rw       in   1  1=read, 0=write
//  cmd_addr     in   6  register address
//  cmd_wdata    in   8  write data
//  cmd_ioup     in   1  pulse IO_update after this write (ignored for reads)
//  rd_valid     out  1  one-cycle pulse, rd_data valid
//  rd_data      out  8  read data, held until next read completes
//  busy         out  1  ~cmd_ready
//  DDS_CSn      out  1  chip select, active low
//  DDS_RWn      out  1  1=read, 0=write
//  DDS_PCLK     out  1  port clock
//  DDS_IOup     out  1  IO_update
//  DDS_DataOut  out  8  data driven to pins
//  DDS_ReadEn   out  1  1 = pins tristated (read), 0 = DataOut driven
//  DDS_DataIn   in   8  data from pins
// BEHAVIOUR
//  Reset (async, immediate, also mid-transaction): state=IDLE, CSn=1, RWn=1, PCLK=0,
//   IOup=0, ReadEn=0, DataOut=0, rd_valid=0, rd_data=0, counters=0. Aborted command is lost.
//  All pin outputs registered. cmd fields latched on acceptance; inputs ignored otherwise.
//  FSM: IDLE->SETUP->A_LO->A_HI->[TURN if read]->D_LO->D_HI->HOLD->[IOUP if write&ioup]->IDLE.
//  Each state except IDLE/IOUP lasts exactly CLK_DIV cycles (phase counter, wraps to 0 on exit);
//   IOUP lasts IOUP_W cycles.
//  SETUP: CSn=0, RWn=cmd_rw, PCLK=0, DataOut={2'b00,addr}, ReadEn=0.
//  A_LO: PCLK=0; A_HI: PCLK=1 (DDS latches address on this rising edge).
//  TURN (read only): ReadEn=1, PCLK=0, DataOut=0.
//  D_LO: PCLK=0; write: DataOut=wdata, ReadEn=0; read: ReadEn=1.
//  D_HI: PCLK=1; read: DDS_DataIn sampled into rd_data on the last D_HI cycle.
//  HOLD: PCLK=0, CSn=1, RWn=1, ReadEn=0, DataOut=0; read: rd_valid=1 on first HOLD cycle.
//  IOUP: IOup=1 for IOUP_W cycles, CSn=1.
//  RWn changes only while CSn=1 or in SETUP; DataOut never changes while PCLK=1.
//  ReadEn=1 only within TURN..D_HI; never drive and tristate in same cycle as direction flip.
//  Transaction length (acceptance edge to cmd_ready high): write 6*CLK_DIV+1,
//   write+ioup 6*CLK_DIV+IOUP_W+1, read 7*CLK_DIV+1 cycles.
//  cmd_valid held high back-to-back: next command accepted the cycle cmd_ready rises;
//   minimum one IDLE cycle with CSn=1 between transactions.
//  cmd_ioup on a read: no IOUP state, no pulse.
//  CLK_DIV=1 must work (PCLK = clk/2 during address/data phases).
// TESTING
//  CLK_DIV=2: write addr 0x05 data 0xA5 ioup=0 -> CSn low cycles 1-10, PCLK rises at 5 and 9,
//   DataOut 0x05 at rise 5, 0xA5 at rise 9, RWn=0, ReadEn=0 throughout, cmd_ready at cycle 13.
//  Same write with ioup=1, IOUP_W=4 -> IOup high cycles 13-16 with CSn=1, cmd_ready at cycle 17.
//  Read addr 0x1F, model drives 0x3C while ReadEn=1 -> RWn=1, ReadEn 1 cycles 7-12,
//   rd_valid pulse cycle 13 with rd_data=0x3C, cmd_ready at cycle 15.
//  Back-to-back write then read, cmd_valid held high -> exactly one IDLE cycle (CSn=1)
//   between them, both transactions pin-correct, single rd_valid.
//  Assert rstn low during D_HI of a write -> outputs return to reset values in same cycle,
//   no IOup, no rd_valid; after release a new write completes normally.
//  CLK_DIV=1, IOUP_W=1 read with ioup=1 -> 8-cycle transaction, no IOup pulse, correct data.

Source files
------------

// File: rtl/dds_par_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_par_ctrl
// Description : Sequencer for the DDS byte-wide parallel port. Converts single
//               register read/write commands into pin-level bus cycles
//               (CSn/RWn/PCLK/IO_update/8-bit bidirectional data) and returns
//               read data. Can optionally pulse IO_update after a write.
//
// Parameters  : CLK_DIV  clk cycles per bus phase (PCLK half-period), >= 1
//               IOUP_W   IO_update pulse width in clk cycles, >= 1
//
// Ports       : clk          in   system clock, rising edge
//               rstn         in   asynchronous active-low reset
//               cmd_valid    in   command request
//               cmd_ready    out  high in IDLE only
//               cmd_rw       in   1 = read, 0 = write
//               cmd_addr     in   6-bit register address
//               cmd_wdata    in   8-bit write data
//               cmd_ioup     in   pulse IO_update after this write
//               rd_valid     out  one-cycle pulse, rd_data valid
//               rd_data      out  read data, held until next read completes
//               busy         out  inverse of cmd_ready
//               DDS_CSn      out  chip select, active low
//               DDS_RWn      out  1 = read, 0 = write
//               DDS_PCLK     out  port clock
//               DDS_IOup     out  IO_update
//               DDS_DataOut  out  data driven to pins
//               DDS_ReadEn   out  1 = pins tristated (read)
//               DDS_DataIn   in   data from pins
//
// Revision    : 1.0  initial release
// ============================================================================
module dds_par_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int IOUP_W  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_ioup,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       DDS_CSn,
    output logic       DDS_RWn,
    output logic       DDS_PCLK,
    output logic       DDS_IOup,
    output logic [7:0] DDS_DataOut,
    output logic       DDS_ReadEn,
    input  logic [7:0] DDS_DataIn
);

    // Phase counter is shared by the bus phases and the IO_update pulse.
    localparam int c_CNT_MAX = (CLK_DIV > IOUP_W) ? CLK_DIV : IOUP_W;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_DIV_LAST  = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_IOUP_LAST = c_CNT_W'(IOUP_W - 1);

    localparam logic [3:0] c_S_IDLE  = 4'd0;
    localparam logic [3:0] c_S_SETUP = 4'd1;
    localparam logic [3:0] c_S_A_LO  = 4'd2;
    localparam logic [3:0] c_S_A_HI  = 4'd3;
    localparam logic [3:0] c_S_TURN  = 4'd4;
    localparam logic [3:0] c_S_D_LO  = 4'd5;
    localparam logic [3:0] c_S_D_HI  = 4'd6;
    localparam logic [3:0] c_S_HOLD  = 4'd7;
    localparam logic [3:0] c_S_IOUP  = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_last;
    logic               w_accept;

    // Latched command
    logic               r_rw;
    logic [5:0]         r_addr;
    logic [7:0]         r_wdata;
    logic               r_ioup_req;

    // Registered pin / status outputs and their next values
    logic               r_csn, r_rwn, r_pclk, r_ioup, r_ren, r_rd_valid;
    logic [7:0]         r_dout, r_rd_data;
    logic               w_csn, w_rwn, w_pclk, w_ioup, w_ren;
    logic [7:0]         w_dout;

    // During the acceptance cycle the command is not latched yet, so the
    // SETUP pin values come straight from the command inputs.
    logic               w_rw;
    logic [5:0]         w_addr;
    logic               w_rd_sample;

    assign w_accept    = cmd_valid && (r_state == c_S_IDLE);
    assign w_rw        = w_accept ? cmd_rw   : r_rw;
    assign w_addr      = w_accept ? cmd_addr : r_addr;
    assign w_last      = (r_state == c_S_IOUP) ? (r_cnt == c_IOUP_LAST)
                                               : (r_cnt == c_DIV_LAST);
    assign w_rd_sample = (r_state == c_S_D_HI) && w_last && r_rw;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == c_S_IDLE) begin
            if (cmd_valid) begin
                w_state_nxt = c_S_SETUP;
            end
        end else if (!w_last) begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end else begin
            w_cnt_nxt = '0;
            case (r_state)
                c_S_SETUP: w_state_nxt = c_S_A_LO;
                c_S_A_LO:  w_state_nxt = c_S_A_HI;
                c_S_A_HI:  w_state_nxt = r_rw ? c_S_TURN : c_S_D_LO;
                c_S_TURN:  w_state_nxt = c_S_D_LO;
                c_S_D_LO:  w_state_nxt = c_S_D_HI;
                c_S_D_HI:  w_state_nxt = c_S_HOLD;
                c_S_HOLD:  w_state_nxt = (!r_rw && r_ioup_req) ? c_S_IOUP : c_S_IDLE;
                c_S_IOUP:  w_state_nxt = c_S_IDLE;
                default:   w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pin values for the state being entered; registered below so the
    // pins change exactly on the state boundary.
    // ------------------------------------------------------------------
    always_comb begin
        w_csn  = 1'b1;
        w_rwn  = 1'b1;
        w_pclk = 1'b0;
        w_ioup = 1'b0;
        w_ren  = 1'b0;
        w_dout = '0;
        case (w_state_nxt)
            c_S_SETUP, c_S_A_LO: begin
                w_csn  = 1'b0;
                w_rwn  = w_rw;
                w_dout = {2'b00, w_addr};
            end
            c_S_A_HI: begin
                w_csn  = 1'b0;
                w_rwn  = w_rw;
                w_pclk = 1'b1;
                w_dout = {2'b00, w_addr};
            end
            c_S_TURN: begin
                // Stop driving one phase before the DDS starts driving.
                w_csn  = 1'b0;
                w_rwn  = w_rw;
                w_ren  = 1'b1;
            end
            c_S_D_LO, c_S_D_HI: begin
                w_csn  = 1'b0;
                w_rwn  = w_rw;
                w_pclk = (w_state_nxt == c_S_D_HI);
                if (w_rw) begin
                    w_ren  = 1'b1;
                end else begin
                    w_dout = r_wdata;
                end
            end
            c_S_IOUP: begin
                w_ioup = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_S_IDLE;
            r_cnt      <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ioup_req <= 1'b0;
            r_csn      <= 1'b1;
            r_rwn      <= 1'b1;
            r_pclk     <= 1'b0;
            r_ioup     <= 1'b0;
            r_ren      <= 1'b0;
            r_dout     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_accept) begin
                r_rw       <= cmd_rw;
                r_addr     <= cmd_addr;
                r_wdata    <= cmd_wdata;
                r_ioup_req <= cmd_ioup;
            end
            r_csn      <= w_csn;
            r_rwn      <= w_rwn;
            r_pclk     <= w_pclk;
            r_ioup     <= w_ioup;
            r_ren      <= w_ren;
            r_dout     <= w_dout;
            // Sample on the last PCLK-high cycle; valid pulses on first HOLD cycle.
            r_rd_valid <= w_rd_sample;
            if (w_rd_sample) begin
                r_rd_data <= DDS_DataIn;
            end
        end
    end

    assign cmd_ready   = (r_state == c_S_IDLE);
    assign busy        = ~cmd_ready;
    assign rd_valid    = r_rd_valid;
    assign rd_data     = r_rd_data;
    assign DDS_CSn     = r_csn;
    assign DDS_RWn     = r_rwn;
    assign DDS_PCLK    = r_pclk;
    assign DDS_IOup    = r_ioup;
    assign DDS_DataOut = r_dout;
    assign DDS_ReadEn  = r_ren;

endmodule
`default_nettype wire

// File: tb/tb_dds_par_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_par_ctrl
// Description : Directed bench for dds_par_ctrl. One instance at CLK_DIV=2,
//               IOUP_W=4 and one at CLK_DIV=1, IOUP_W=1. Pin activity is
//               captured per cycle (cycle 0 = cycle ending in the acceptance
//               edge) and compared with hand-derived cycle windows.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dds_par_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    // Instance A: CLK_DIV=2, IOUP_W=4
    logic       cmd_valid, cmd_ready, cmd_rw, cmd_ioup, rd_valid, busy;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata, rd_data;
    logic       dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_readen;
    logic [7:0] dds_dataout, dds_datain, model_byte;
    assign dds_datain = dds_readen ? model_byte : 8'hEE;

    // Instance B: CLK_DIV=1, IOUP_W=1
    logic       cmd_valid1, cmd_ready1, cmd_rw1, cmd_ioup1, rd_valid1, busy1;
    logic [5:0] cmd_addr1;
    logic [7:0] cmd_wdata1, rd_data1;
    logic       dds_csn1, dds_rwn1, dds_pclk1, dds_ioup1, dds_readen1;
    logic [7:0] dds_dataout1, dds_datain1, model_byte1;
    assign dds_datain1 = dds_readen1 ? model_byte1 : 8'hEE;

    dds_par_ctrl #(.CLK_DIV(2), .IOUP_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_ioup(cmd_ioup),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .DDS_CSn(dds_csn), .DDS_RWn(dds_rwn), .DDS_PCLK(dds_pclk),
        .DDS_IOup(dds_ioup), .DDS_DataOut(dds_dataout),
        .DDS_ReadEn(dds_readen), .DDS_DataIn(dds_datain)
    );

    dds_par_ctrl #(.CLK_DIV(1), .IOUP_W(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_rw(cmd_rw1),
        .cmd_addr(cmd_addr1), .cmd_wdata(cmd_wdata1), .cmd_ioup(cmd_ioup1),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .busy(busy1),
        .DDS_CSn(dds_csn1), .DDS_RWn(dds_rwn1), .DDS_PCLK(dds_pclk1),
        .DDS_IOup(dds_ioup1), .DDS_DataOut(dds_dataout1),
        .DDS_ReadEn(dds_readen1), .DDS_DataIn(dds_datain1)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] cap_csn, cap_rwn, cap_pclk, cap_ren, cap_ioup, cap_rdv, cap_rdy, cap_busy;
    logic [7:0]  cap_dout [0:31];
    logic [7:0]  cap_rdd  [0:31];
    logic [31:0] exp_v;

    // Bit mask with bits lo..hi set (cycle window).
    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic clear_cap();
        cap_csn = '0; cap_rwn = '0; cap_pclk = '0; cap_ren = '0;
        cap_ioup = '0; cap_rdv = '0; cap_rdy = '0; cap_busy = '0;
        for (int i = 0; i < 32; i++) begin
            cap_dout[i] = '0;
            cap_rdd[i]  = '0;
        end
    endtask

    task automatic capture(input int k);
        cap_csn[k] = dds_csn;   cap_rwn[k] = dds_rwn;   cap_pclk[k] = dds_pclk;
        cap_ren[k] = dds_readen; cap_ioup[k] = dds_ioup; cap_rdv[k] = rd_valid;
        cap_rdy[k] = cmd_ready; cap_busy[k] = busy;
        cap_dout[k] = dds_dataout; cap_rdd[k] = rd_data;
    endtask

    task automatic capture1(input int k);
        cap_csn[k] = dds_csn1;   cap_rwn[k] = dds_rwn1;   cap_pclk[k] = dds_pclk1;
        cap_ren[k] = dds_readen1; cap_ioup[k] = dds_ioup1; cap_rdv[k] = rd_valid1;
        cap_rdy[k] = cmd_ready1; cap_busy[k] = busy1;
        cap_dout[k] = dds_dataout1; cap_rdd[k] = rd_data1;
    endtask

    // Returns at a falling edge with cmd_ready high (bounded wait).
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: cmd_ready=%b required 1", name, cmd_ready);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 1'b0;
        cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_wdata = '0; cmd_ioup = 0;
        cmd_valid1 = 0; cmd_rw1 = 0; cmd_addr1 = '0; cmd_wdata1 = '0; cmd_ioup1 = 0;
        model_byte = 8'h00; model_byte1 = 8'h00;
        repeat (3) @(negedge clk);
        // {csn,rwn,pclk,ioup,ren,dout,rd_valid,rd_data,ready,busy}
        checks++;
        if ({dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_readen, dds_dataout, rd_valid, rd_data, cmd_ready, busy}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_in_reset: got csn=%b rwn=%b pclk=%b ioup=%b ren=%b dout=%h rdv=%b rdd=%h rdy=%b busy=%b required 1 1 0 0 0 00 0 00 1 0",
                     dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_readen, dds_dataout, rd_valid, rd_data, cmd_ready, busy);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_readen, dds_dataout, rd_valid, cmd_ready}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_idle: got csn=%b rwn=%b pclk=%b ioup=%b ren=%b dout=%h rdv=%b rdy=%b required 1 1 0 0 0 00 0 1",
                     dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_readen, dds_dataout, rd_valid, cmd_ready);
        end
        checks++;
        if ({dds_csn1, dds_pclk1, dds_readen1, cmd_ready1} !== 4'b1001) begin
            errors++;
            $display("FAIL rst_idle_div1: got %b required 1001", {dds_csn1, dds_pclk1, dds_readen1, cmd_ready1});
        end
    endtask

    // ------------------------------------------------------------------
    // Write 0x05 <- 0xA5, optionally with IO_update.
    task automatic test_write(input logic ioup, input string name);
        int n;
        n = ioup ? 18 : 14;
        wait_ready(name);
        clear_cap();
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 6'h05; cmd_wdata = 8'hA5; cmd_ioup = ioup;
        capture(0);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            capture(k);
            if (k == 1) begin
                // Scramble inputs after acceptance; they must be ignored.
                cmd_valid = 0; cmd_addr = 6'h3F; cmd_wdata = 8'h00; cmd_ioup = ~ioup; cmd_rw = 1;
            end
        end
        exp_v = ~rng(1, 10) & rng(0, n);
        checks++;
        if (cap_csn !== exp_v) begin errors++; $display("FAIL %s_csn: got %h required %h", name, cap_csn, exp_v); end
        checks++;
        if (cap_rwn !== exp_v) begin errors++; $display("FAIL %s_rwn: got %h required %h", name, cap_rwn, exp_v); end
        exp_v = rng(5, 6) | rng(9, 10);
        checks++;
        if (cap_pclk !== exp_v) begin errors++; $display("FAIL %s_pclk: got %h required %h", name, cap_pclk, exp_v); end
        checks++;
        if (cap_ren !== 32'h0) begin errors++; $display("FAIL %s_readen: got %h required 0", name, cap_ren); end
        exp_v = ioup ? rng(13, 16) : 32'h0;
        checks++;
        if (cap_ioup !== exp_v) begin errors++; $display("FAIL %s_ioup: got %h required %h", name, cap_ioup, exp_v); end
        checks++;
        if (cap_rdv !== 32'h0) begin errors++; $display("FAIL %s_rd_valid: got %h required 0", name, cap_rdv); end
        exp_v = ioup ? (rng(0, 0) | rng(17, 18)) : (rng(0, 0) | rng(13, 14));
        checks++;
        if (cap_rdy !== exp_v) begin errors++; $display("FAIL %s_ready: got %h required %h", name, cap_rdy, exp_v); end
        exp_v = ~exp_v & rng(0, n);
        checks++;
        if (cap_busy !== exp_v) begin errors++; $display("FAIL %s_busy: got %h required %h", name, cap_busy, exp_v); end
        checks++;
        if ({cap_dout[1], cap_dout[5], cap_dout[6], cap_dout[9], cap_dout[10], cap_dout[11]} !== {8'h05, 8'h05, 8'h05, 8'hA5, 8'hA5, 8'h00}) begin
            errors++;
            $display("FAIL %s_dataout: got c1=%h c5=%h c6=%h c9=%h c10=%h c11=%h required 05 05 05 a5 a5 00",
                     name, cap_dout[1], cap_dout[5], cap_dout[6], cap_dout[9], cap_dout[10], cap_dout[11]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_read();
        wait_ready("rd");
        clear_cap();
        model_byte = 8'h3C;
        cmd_valid = 1; cmd_rw = 1; cmd_addr = 6'h1F; cmd_wdata = 8'h99; cmd_ioup = 0;
        capture(0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            capture(k);
            if (k == 1) begin
                cmd_valid = 0; cmd_addr = 6'h00; cmd_rw = 0;
            end
        end
        exp_v = ~rng(1, 12) & rng(0, 16);
        checks++;
        if (cap_csn !== exp_v) begin errors++; $display("FAIL rd_csn: got %h required %h", cap_csn, exp_v); end
        exp_v = rng(0, 16);
        checks++;
        if (cap_rwn !== exp_v) begin errors++; $display("FAIL rd_rwn: got %h required %h", cap_rwn, exp_v); end
        exp_v = rng(7, 12);
        checks++;
        if (cap_ren !== exp_v) begin errors++; $display("FAIL rd_readen: got %h required %h", cap_ren, exp_v); end
        exp_v = rng(5, 6) | rng(11, 12);
        checks++;
        if (cap_pclk !== exp_v) begin errors++; $display("FAIL rd_pclk: got %h required %h", cap_pclk, exp_v); end
        exp_v = rng(13, 13);
        checks++;
        if (cap_rdv !== exp_v) begin errors++; $display("FAIL rd_rd_valid: got %h required %h", cap_rdv, exp_v); end
        exp_v = rng(0, 0) | rng(15, 16);
        checks++;
        if (cap_rdy !== exp_v) begin errors++; $display("FAIL rd_ready: got %h required %h", cap_rdy, exp_v); end
        checks++;
        if ({cap_rdd[13], cap_rdd[16]} !== {8'h3C, 8'h3C}) begin
            errors++; $display("FAIL rd_data: got c13=%h c16=%h required 3c 3c", cap_rdd[13], cap_rdd[16]);
        end
        checks++;
        if ({cap_dout[1], cap_dout[5], cap_dout[7], cap_dout[11]} !== {8'h1F, 8'h1F, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL rd_dataout: got c1=%h c5=%h c7=%h c11=%h required 1f 1f 00 00", cap_dout[1], cap_dout[5], cap_dout[7], cap_dout[11]);
        end
        checks++;
        if (cap_ioup !== 32'h0) begin errors++; $display("FAIL rd_ioup: got %h required 0", cap_ioup); end
    endtask

    // ------------------------------------------------------------------
    // Write then read with cmd_valid held high; read accepted on edge 14.
    task automatic test_back_to_back();
        wait_ready("b2b");
        clear_cap();
        model_byte = 8'h5A;
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 6'h05; cmd_wdata = 8'hA5; cmd_ioup = 0;
        capture(0);
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            capture(k);
            if (k == 1) begin
                cmd_rw = 1; cmd_addr = 6'h2A; cmd_wdata = 8'h11;
            end
            if (k == 14) cmd_valid = 0;
        end
        exp_v = ~(rng(1, 10) | rng(14, 25)) & rng(0, 29);
        checks++;
        if (cap_csn !== exp_v) begin errors++; $display("FAIL b2b_csn: got %h required %h", cap_csn, exp_v); end
        exp_v = ~rng(1, 10) & rng(0, 29);
        checks++;
        if (cap_rwn !== exp_v) begin errors++; $display("FAIL b2b_rwn: got %h required %h", cap_rwn, exp_v); end
        exp_v = rng(5, 6) | rng(9, 10) | rng(18, 19) | rng(24, 25);
        checks++;
        if (cap_pclk !== exp_v) begin errors++; $display("FAIL b2b_pclk: got %h required %h", cap_pclk, exp_v); end
        exp_v = rng(20, 25);
        checks++;
        if (cap_ren !== exp_v) begin errors++; $display("FAIL b2b_readen: got %h required %h", cap_ren, exp_v); end
        exp_v = rng(26, 26);
        checks++;
        if (cap_rdv !== exp_v) begin errors++; $display("FAIL b2b_rd_valid: got %h required %h", cap_rdv, exp_v); end
        exp_v = rng(0, 0) | rng(13, 13) | rng(28, 29);
        checks++;
        if (cap_rdy !== exp_v) begin errors++; $display("FAIL b2b_ready: got %h required %h", cap_rdy, exp_v); end
        checks++;
        if ({cap_dout[9], cap_dout[14], cap_dout[18], cap_rdd[26]} !== {8'hA5, 8'h2A, 8'h2A, 8'h5A}) begin
            errors++;
            $display("FAIL b2b_data: got dout9=%h dout14=%h dout18=%h rdd26=%h required a5 2a 2a 5a",
                     cap_dout[9], cap_dout[14], cap_dout[18], cap_rdd[26]);
        end
    endtask

    // ------------------------------------------------------------------
    // Reset asserted in the first D_HI cycle of a write with IO_update.
    task automatic test_reset_mid();
        int pulses;
        wait_ready("rstmid");
        cmd_valid = 1; cmd_rw = 0; cmd_addr = 6'h07; cmd_wdata = 8'h77; cmd_ioup = 1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 0;
        end
        checks++;
        if ({dds_pclk, dds_csn, dds_dataout} !== {1'b1, 1'b0, 8'h77}) begin
            errors++; $display("FAIL rstmid_pre: got pclk=%b csn=%b dout=%h required 1 0 77", dds_pclk, dds_csn, dds_dataout);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_readen, dds_dataout, rd_valid, rd_data, cmd_ready}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: got csn=%b rwn=%b pclk=%b ioup=%b ren=%b dout=%h rdv=%b rdd=%h rdy=%b required 1 1 0 0 0 00 0 00 1",
                     dds_csn, dds_rwn, dds_pclk, dds_ioup, dds_readen, dds_dataout, rd_valid, rd_data, cmd_ready);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dds_ioup === 1'b1 || rd_valid === 1'b1 || dds_csn !== 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles required 0", pulses); end
    endtask

    // ------------------------------------------------------------------
    // CLK_DIV=1, IOUP_W=1 read with cmd_ioup set (must be ignored).
    task automatic test_clkdiv1();
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        clear_cap();
        model_byte1 = 8'hC3;
        cmd_valid1 = 1; cmd_rw1 = 1; cmd_addr1 = 6'h2C; cmd_wdata1 = 8'h00; cmd_ioup1 = 1;
        capture1(0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            capture1(k);
            if (k == 1) cmd_valid1 = 0;
        end
        exp_v = ~rng(1, 6) & rng(0, 10);
        checks++;
        if (cap_csn !== exp_v) begin errors++; $display("FAIL div1_csn: got %h required %h", cap_csn, exp_v); end
        exp_v = rng(3, 3) | rng(6, 6);
        checks++;
        if (cap_pclk !== exp_v) begin errors++; $display("FAIL div1_pclk: got %h required %h", cap_pclk, exp_v); end
        exp_v = rng(4, 6);
        checks++;
        if (cap_ren !== exp_v) begin errors++; $display("FAIL div1_readen: got %h required %h", cap_ren, exp_v); end
        exp_v = rng(0, 0) | rng(8, 10);
        checks++;
        if (cap_rdy !== exp_v) begin errors++; $display("FAIL div1_ready: got %h required %h", cap_rdy, exp_v); end
        checks++;
        if (cap_ioup !== 32'h0) begin errors++; $display("FAIL div1_ioup: got %h required 0", cap_ioup); end
        exp_v = rng(7, 7);
        checks++;
        if (cap_rdv !== exp_v) begin errors++; $display("FAIL div1_rd_valid: got %h required %h", cap_rdv, exp_v); end
        checks++;
        if ({cap_rdd[7], cap_dout[1], cap_dout[3], cap_rwn[1]} !== {8'hC3, 8'h2C, 8'h2C, 1'b1}) begin
            errors++;
            $display("FAIL div1_data: got rdd7=%h dout1=%h dout3=%h rwn1=%b required c3 2c 2c 1",
                     cap_rdd[7], cap_dout[1], cap_dout[3], cap_rwn[1]);
        end
    endtask

    initial begin
        test_reset();
        test_write(1'b0, "wr");
        test_write(1'b1, "wrio");
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_write(1'b0, "wr_after_rst");
        test_clkdiv1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
